// File: rtl/mesh.sv
// Linear PE array that routes packets by odd-even transposition sort on the address field, then commits the data.
// Optional macro MESH_ADDR_CHECK_EN sets a sticky err flag at commit if any PE holds a foreign address.
module mesh #(
  parameter int N           = 4,
  parameter int SORT_CYCLES = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [N*DATA_WIDTH-1:0] mem_flat,
  output logic                    done,
  output logic                    err
);

  // state   | meaning
  // ST_SORT | compare-exchange phases; commit on the cycle the counter reaches SORT_CYCLES
  // ST_DONE | memories committed, all state frozen until reset
  typedef enum logic [0:0] {ST_SORT, ST_DONE} state_t;

  localparam int CW = $clog2(SORT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(SORT_CYCLES);

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] addr_q [N];
  logic [ADDR_WIDTH-1:0] addr_nxt [N];
  logic [DATA_WIDTH-1:0] data_q [N];
  logic [DATA_WIDTH-1:0] data_nxt [N];
  logic [DATA_WIDTH-1:0] mem_q [N];

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    if (state == ST_SORT && cnt == LAST) begin
      commit    = 1'b1;
      state_nxt = ST_DONE;
    end
  end

  // Pairs start at PE 0 on even phases and PE 1 on odd phases; pairs are disjoint.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      addr_nxt[i] = addr_q[i];
      data_nxt[i] = data_q[i];
    end
    for (int i = 0; i < N - 1; i++) begin
      if ((i % 2) == int'(cnt[0]) && addr_q[i] > addr_q[i+1]) begin
        addr_nxt[i]   = addr_q[i+1];
        data_nxt[i]   = data_q[i+1];
        addr_nxt[i+1] = addr_q[i];
        data_nxt[i+1] = data_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_SORT;
      cnt   <= '0;
      for (int k = 0; k < N; k++) begin
        addr_q[k] <= ADDR_WIDTH'(N - 1 - k);
        data_q[k] <= DATA_WIDTH'(k);
        mem_q[k]  <= '0;
      end
    end else begin
      state <= state_nxt;
      if (state == ST_SORT) begin
        if (commit) begin
          for (int k = 0; k < N; k++) mem_q[k] <= data_q[k];
        end else begin
          for (int k = 0; k < N; k++) begin
            addr_q[k] <= addr_nxt[k];
            data_q[k] <= data_nxt[k];
          end
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

`ifdef MESH_ADDR_CHECK_EN
  logic err_q;
  logic misplaced;

  always_comb begin
    misplaced = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (addr_q[i] != ADDR_WIDTH'(i)) misplaced = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                    err_q <= 1'b0;
    else if (commit && misplaced) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign done = (state == ST_DONE);

  for (genvar g = 0; g < N; g++) begin : g_mem
    assign mem_flat[g*DATA_WIDTH +: DATA_WIDTH] = mem_q[g];
  end

endmodule

// File: tb/tb_mesh.sv
// Bench for mesh: three instances (4/4 nominal, 4/1 short sort, 8/8 scaled) share clock and reset.
// Expected results are queued at reset release and popped when each instance raises done.
module tb_mesh;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] mem_a, mem_b;
  logic [255:0] mem_c;
  logic         done_a, done_b, done_c;
  logic         err_a, err_b, err_c;

  always #5 clk = ~clk;

  mesh #(.N(4), .SORT_CYCLES(4), .DATA_WIDTH(32), .ADDR_WIDTH(2)) u_a (
    .clk(clk), .rst(rst), .mem_flat(mem_a), .done(done_a), .err(err_a));
  mesh #(.N(4), .SORT_CYCLES(1), .DATA_WIDTH(32), .ADDR_WIDTH(2)) u_b (
    .clk(clk), .rst(rst), .mem_flat(mem_b), .done(done_b), .err(err_b));
  mesh #(.N(8), .SORT_CYCLES(8), .DATA_WIDTH(32), .ADDR_WIDTH(3)) u_c (
    .clk(clk), .rst(rst), .mem_flat(mem_c), .done(done_c), .err(err_c));

  typedef struct {
    logic [255:0] mem;
    int           edge_n;
    logic         err;
  } exp_t;

  exp_t q_a[$], q_b[$], q_c[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_n = 0;
  bit   seen_a, seen_b, seen_c;

`ifdef MESH_ADDR_CHECK_EN
  localparam logic ERR_SHORT = 1'b1;
`else
  localparam logic ERR_SHORT = 1'b0;
`endif

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] sorted_mem(input int n);
    logic [255:0] m = '0;
    for (int j = 0; j < n; j++) m[j*32 +: 32] = 32'(n - 1 - j);
    return m;
  endfunction

  function automatic logic [255:0] short_mem();
    logic [255:0] m = '0;
    m[0*32 +: 32] = 32'd1;
    m[1*32 +: 32] = 32'd0;
    m[2*32 +: 32] = 32'd3;
    m[3*32 +: 32] = 32'd2;
    return m;
  endfunction

  task automatic push_all(input int edge_a, input int edge_b, input int edge_c);
    exp_t e;
    e.mem = sorted_mem(4); e.edge_n = edge_a; e.err = 1'b0;      q_a.push_back(e);
    e.mem = short_mem();   e.edge_n = edge_b; e.err = ERR_SHORT; q_b.push_back(e);
    e.mem = sorted_mem(8); e.edge_n = edge_c; e.err = 1'b0;      q_c.push_back(e);
    seen_a = 0; seen_b = 0; seen_c = 0;
  endtask

  task automatic pop_check(input string tag, input int which, input logic [255:0] obs_mem,
                           input logic obs_err);
    exp_t e;
    int   sz;
    sz = (which == 0) ? q_a.size() : (which == 1) ? q_b.size() : q_c.size();
    checks++;
    assert (sz > 0) else begin
      errors++;
      $error("FAIL %s_spurious_done observed=done expected=no_pending_result", tag);
    end
    if (sz > 0) begin
      case (which)
        0:       e = q_a.pop_front();
        1:       e = q_b.pop_front();
        default: e = q_c.pop_front();
      endcase
      check({tag, "_mem"}, obs_mem, e.mem);
      check({tag, "_done_edge"}, 256'(edge_n), 256'(e.edge_n));
      check({tag, "_err"}, 256'(obs_err), 256'(e.err));
    end
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      edge_n++;
      #1;
      if (!rst && done_a && !seen_a) begin seen_a = 1; pop_check("a", 0, 256'(mem_a), err_a); end
      if (!rst && done_b && !seen_b) begin seen_b = 1; pop_check("b", 1, 256'(mem_b), err_b); end
      if (!rst && done_c && !seen_c) begin seen_c = 1; pop_check("c", 2, mem_c, err_c); end
    end
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_a_pending"}, 256'(q_a.size()), 256'(0));
    check({tag, "_b_pending"}, 256'(q_b.size()), 256'(0));
    check({tag, "_c_pending"}, 256'(q_c.size()), 256'(0));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_mem_a"}, 256'(mem_a), 256'(0));
    check({tag, "_mem_b"}, 256'(mem_b), 256'(0));
    check({tag, "_mem_c"}, mem_c, 256'(0));
    check({tag, "_done"}, 256'({done_a, done_b, done_c}), 256'(0));
    check({tag, "_err"}, 256'({err_a, err_b, err_c}), 256'(0));
  endtask

  initial begin
    // Reset hold for two edges.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset_hold");

    // Nominal run: expectations queued at release.
    push_all(5, 2, 9);
    rst    = 1'b0;
    edge_n = 0;
    run(100);
    check_drained("nominal");

    // Results hold for 50 more cycles.
    run(50);
    check("hold_mem_a", 256'(mem_a), sorted_mem(4));
    check("hold_mem_b", 256'(mem_b), short_mem());
    check("hold_mem_c", mem_c, sorted_mem(8));
    check("hold_done", 256'({done_a, done_b, done_c}), 256'(3'b111));
    check("hold_err", 256'({err_a, err_b, err_c}), 256'({1'b0, ERR_SHORT, 1'b0}));

    // Reset mid-operation: restart, run one edge, reset on edge 2, then release.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    edge_n = 0;
    run(1);
    @(negedge clk);
    rst = 1'b1;
    run(1);
    @(negedge clk);
    check_reset_state("midop_reset");
    push_all(5, 2, 9);
    rst    = 1'b0;
    edge_n = 0;
    run(30);
    check_drained("midop");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
